comb_datapath: RTL and testbench

Datapath for the stack-driven binomial-coefficient engine. It holds the working `n`/`m` registers, a LIFO of `DW`-bit operands, the push-data selector and the leaf counter that accumulates the result. It is driven cycle-by-cycle by the existing `controller` FSM and returns the status flags that FSM branches on (`eq_zero`, `nm_eq`, `empty`, `stack_out`).

---
 rtl/comb_pkg.sv | 38 +++
 rtl/lifo_stack.sv | 80 ++++++++
 rtl/comb_datapath.sv | 99 +++++++++
 tb/tb_comb_datapath.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/comb_pkg.sv
// rtl/comb_pkg.sv - shared encodings, defaults and bundle widths for the binomial engine
package comb_pkg;

  localparam int DW_DEF    = 4;
  localparam int DEPTH_DEF = 32;
  localparam int RW_DEF    = 16;

  typedef enum logic [1:0] {
    SEL_N   = 2'd0,
    SEL_NM1 = 2'd1,
    SEL_M   = 2'd2,
    SEL_MM1 = 2'd3
  } push_sel_e;

  // Controller-to-datapath strobes: ld_n, ld_m, s1, s2, s0[1:0], push, pop, top, cnt
  localparam int CTRL_W = 10;
  // Datapath-to-controller flags: eq_zero, nm_eq, empty
  localparam int STAT_W = 3;

  typedef struct packed {
    logic      ld_n;
    logic      ld_m;
    logic      s1;
    logic      s2;
    push_sel_e s0;
    logic      push;
    logic      pop;
    logic      top;
    logic      cnt;
  } ctrl_t;

  typedef struct packed {
    logic eq_zero;
    logic nm_eq;
    logic empty;
  } stat_t;

endpackage

// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - operand LIFO with sticky overflow/underflow and push+pop replace
module lifo_stack #(
  parameter int DW    = 4,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          top_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          ovf_o,
  output logic          udf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] SP_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   sp_q, sp_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic          empty, full;
  logic          do_repl, do_push, do_pop;
  logic          wr_en;
  logic [AW:0]   sp_m1;
  logic [AW-1:0] top_idx, wr_addr;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == SP_FULL);
  assign sp_m1   = sp_q - SP_ONE;
  assign top_idx = sp_m1[AW-1:0];

  // Push+pop on a non-empty stack overwrites the top; on an empty stack it is a plain push.
  assign do_repl = push_i && pop_i && !empty;
  assign do_push = push_i && !do_repl && !full;
  assign do_pop  = pop_i && !push_i && !empty;
  assign wr_en   = do_repl || do_push;
  assign wr_addr = do_repl ? top_idx : sp_q[AW-1:0];

  always_comb begin
    sp_d  = sp_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (do_push) sp_d = sp_q + SP_ONE;
    if (do_pop)  sp_d = sp_m1;
    if (push_i && !do_repl && full) ovf_d = 1'b1;
    if (pop_i && !push_i && empty)  udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Memory is not reset; its contents are meaningless once sp is cleared.
  always_ff @(posedge clk) begin
    if (rst_n && !clr_i && wr_en) mem_q[wr_addr] <= wdata_i;
  end

  assign rdata_o = (top_i && !empty) ? mem_q[top_idx] : '0;
  assign empty_o = empty;
  assign full_o  = full;
  assign ovf_o   = ovf_q;
  assign udf_o   = udf_q;

endmodule

// File: rtl/comb_datapath.sv
// rtl/comb_datapath.sv - n/m registers, push-data select, operand LIFO and leaf counter
module comb_datapath
  import comb_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int RW    = RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [DW-1:0] n_in,
  input  logic [DW-1:0] m_in,
  input  logic          ld_n,
  input  logic          ld_m,
  input  logic          s1,
  input  logic          s2,
  input  logic [1:0]    s0,
  input  logic          push,
  input  logic          pop,
  input  logic          top,
  input  logic          cnt,
  output logic          eq_zero,
  output logic          nm_eq,
  output logic          empty,
  output logic [DW-1:0] stack_out,
  output logic [RW-1:0] result,
  output logic          ovf,
  output logic          udf
);

  localparam logic [DW-1:0] DW_ONE = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0] RW_ONE = {{(RW-1){1'b0}}, 1'b1};

  logic [DW-1:0] n_q, n_d;
  logic [DW-1:0] m_q, m_d;
  logic [RW-1:0] result_q, result_d;
  logic [DW-1:0] push_data;
  logic          full_unused;

  // Loads from the stack take the pre-edge top, so pop+load captures the popped entry.
  always_comb begin
    n_d = n_q;
    m_d = m_q;
    if (ld_n) n_d = s1 ? n_in : stack_out;
    if (ld_m) m_d = s2 ? m_in : stack_out;
  end

  always_comb begin
    push_data = n_q;
    case (push_sel_e'(s0))
      SEL_N:   push_data = n_q;
      SEL_NM1: push_data = n_q - DW_ONE;
      SEL_M:   push_data = m_q;
      SEL_MM1: push_data = m_q - DW_ONE;
      default: push_data = n_q;
    endcase
  end

  always_comb begin
    result_d = result_q;
    if (cnt && (result_q != '1)) result_d = result_q + RW_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      n_q      <= '0;
      m_q      <= '0;
      result_q <= '0;
    end else begin
      n_q      <= n_d;
      m_q      <= m_d;
      result_q <= result_d;
    end
  end

  lifo_stack #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .push_i  (push),
    .pop_i   (pop),
    .top_i   (top),
    .wdata_i (push_data),
    .rdata_o (stack_out),
    .empty_o (empty),
    .full_o  (full_unused),
    .ovf_o   (ovf),
    .udf_o   (udf)
  );

  assign eq_zero = (m_q == '0);
  assign nm_eq   = (n_q == m_q);
  assign result  = result_q;

endmodule

// File: tb/tb_comb_datapath.sv
// tb/tb_comb_datapath.sv - randomized and directed checks of comb_datapath against a queue model
module tb_comb_datapath;

  localparam int DW    = 4;
  localparam int DEPTH = 32;
  localparam int RW    = 16;

  logic          clk = 1'b0;
  logic          rst_n, clr;
  logic [DW-1:0] n_in, m_in;
  logic          ld_n, ld_m, s1, s2;
  logic [1:0]    s0;
  logic          push, pop, top, cnt;
  logic          eq_zero, nm_eq, empty, ovf, udf;
  logic [DW-1:0] stack_out;
  logic [RW-1:0] result;

  comb_datapath #(.DW(DW), .DEPTH(DEPTH), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .n_in(n_in), .m_in(m_in),
    .ld_n(ld_n), .ld_m(ld_m), .s1(s1), .s2(s2), .s0(s0),
    .push(push), .pop(pop), .top(top), .cnt(cnt),
    .eq_zero(eq_zero), .nm_eq(nm_eq), .empty(empty), .stack_out(stack_out),
    .result(result), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // reference state
  int mn, mm, mres;
  bit movf, mudf;
  int stk[$];

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int model_top();
    return (top && stk.size() > 0) ? stk[$] : 0;
  endfunction

  task automatic idle();
    ld_n = 0; ld_m = 0; s1 = 0; s2 = 0; s0 = 2'd0;
    push = 0; pop = 0; top = 0; cnt = 0; clr = 0;
  endtask

  task automatic model_update();
    int so, pd;
    if (!rst_n || clr) begin
      mn = 0; mm = 0; mres = 0; movf = 0; mudf = 0;
      stk.delete();
      return;
    end
    so = model_top();
    case (s0)
      2'd0: pd = mn;
      2'd1: pd = (mn + 15) % 16;
      2'd2: pd = mm;
      default: pd = (mm + 15) % 16;
    endcase
    if (push && pop && stk.size() > 0) stk[stk.size()-1] = pd;
    else if (push) begin
      if (stk.size() == DEPTH) movf = 1;
      else stk.push_back(pd);
    end else if (pop) begin
      if (stk.size() == 0) mudf = 1;
      else void'(stk.pop_back());
    end
    if (ld_n) mn = s1 ? int'(n_in) : so;
    if (ld_m) mm = s2 ? int'(m_in) : so;
    if (cnt && mres < (1 << RW) - 1) mres++;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".eq_zero"}, int'(eq_zero), int'(mm == 0));
    check({tag, ".nm_eq"}, int'(nm_eq), int'(mn == mm));
    check({tag, ".empty"}, int'(empty), int'(stk.size() == 0));
    check({tag, ".stack_out"}, int'(stack_out), model_top());
    check({tag, ".result"}, int'(result), mres);
    check({tag, ".ovf"}, int'(ovf), int'(movf));
    check({tag, ".udf"}, int'(udf), int'(mudf));
  endtask

  task automatic do_clr();
    idle(); clr = 1; step(); idle();
  endtask

  initial begin
    rst_n = 0; n_in = 0; m_in = 0; idle();
    step(); step();
    rst_n = 1;
    top = 1; #1;
    check("rst_empty", int'(empty), 1);
    check("rst_eq_zero", int'(eq_zero), 1);
    check("rst_nm_eq", int'(nm_eq), 1);
    check("rst_result", int'(result), 0);
    check("rst_stack_out", int'(stack_out), 0);
    check_model("rst");

    // load n=5, m=2
    n_in = 5; m_in = 2; ld_n = 1; ld_m = 1; s1 = 1; s2 = 1;
    step(); idle();
    check("load_eq_zero", int'(eq_zero), 0);
    check("load_nm_eq", int'(nm_eq), 0);

    // push n, m, n-1, m-1 -> 5, 2, 4, 1
    for (int i = 0; i < 4; i++) begin
      push = 1; s0 = (i == 0) ? 2'd0 : (i == 1) ? 2'd2 : (i == 2) ? 2'd1 : 2'd3;
      step(); idle();
    end
    top = 1; #1;
    check("push_top", int'(stack_out), 1);
    pop = 1; ld_m = 1; s2 = 0; top = 1; step(); idle();
    pop = 1; ld_n = 1; s1 = 0; top = 1; step(); idle();
    top = 1; #1;
    check("pop_sp2_top", int'(stack_out), 2);
    check_model("pop_seq");
    push = 1; s0 = 2'd2; step(); idle(); top = 1; #1;
    check("pop_m_val", int'(stack_out), 1);
    pop = 1; step(); idle();
    push = 1; s0 = 2'd0; step(); idle(); top = 1; #1;
    check("pop_n_val", int'(stack_out), 4);
    pop = 1; step(); idle();

    // m-1 wrap with m=0
    m_in = 0; ld_m = 1; s2 = 1; step(); idle();
    push = 1; s0 = 2'd3; step(); idle(); top = 1; #1;
    check("wrap_top", int'(stack_out), 15);
    check("wrap_eq_zero", int'(eq_zero), 1);

    // overflow: 32 pushes of 3, then a 33rd push of 9
    do_clr();
    n_in = 3; ld_n = 1; s1 = 1; step(); idle();
    for (int i = 0; i < DEPTH; i++) begin push = 1; step(); idle(); end
    n_in = 9; ld_n = 1; s1 = 1; step(); idle();
    check("ovf_before", int'(ovf), 0);
    push = 1; s0 = 2'd0; step(); idle(); top = 1; #1;
    check("ovf_set", int'(ovf), 1);
    check("ovf_top_kept", int'(stack_out), 3);
    check_model("ovf");
    for (int i = 0; i < DEPTH - 1; i++) begin pop = 1; step(); idle(); end
    check("ovf_sp31_nonempty", int'(empty), 0);
    pop = 1; step(); idle();
    check("ovf_sp32_drained", int'(empty), 1);
    check("ovf_sticky", int'(ovf), 1);

    // underflow after clear
    do_clr();
    check("clr_ovf", int'(ovf), 0);
    pop = 1; step(); idle();
    check("udf_set", int'(udf), 1);
    check("udf_empty", int'(empty), 1);

    // push+pop replace: sp=3, top=7, n=9
    do_clr();
    n_in = 7; ld_n = 1; s1 = 1; step(); idle();
    for (int i = 0; i < 3; i++) begin push = 1; step(); idle(); end
    n_in = 9; ld_n = 1; s1 = 1; step(); idle();
    push = 1; pop = 1; s0 = 2'd0; step(); idle(); top = 1; #1;
    check("repl_top", int'(stack_out), 9);
    check("repl_udf", int'(udf), 0);
    pop = 1; top = 1; step(); idle(); top = 1; #1;
    check("repl_below1", int'(stack_out), 7);
    pop = 1; step(); idle(); top = 1; #1;
    check("repl_below2", int'(stack_out), 7);
    pop = 1; step(); idle();
    check("repl_sp3", int'(empty), 1);

    // push+pop on empty is a plain push
    n_in = 6; ld_n = 1; s1 = 1; step(); idle();
    push = 1; pop = 1; step(); idle(); top = 1; #1;
    check("pp_empty_top", int'(stack_out), 6);
    check("pp_empty_udf", int'(udf), 0);

    // randomized traffic against the model
    do_clr();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      clr   = ($urandom_range(0, 199) == 0);
      n_in  = DW'($urandom); m_in = DW'($urandom);
      ld_n  = ($urandom_range(0, 3) == 0); ld_m = ($urandom_range(0, 3) == 0);
      s1    = 1'($urandom); s2 = 1'($urandom); s0 = 2'($urandom);
      push  = ($urandom_range(0, 9) < 5); pop = ($urandom_range(0, 9) < 4);
      top   = ($urandom_range(0, 3) != 0); cnt = 1'($urandom);
      #1; check("rnd_pre_stack_out", int'(stack_out), model_top());
      step();
      check_model("rnd");
    end
    rst_n = 1; idle();

    // saturating counter
    do_clr();
    cnt = 1;
    for (int i = 0; i < (1 << RW) + 3; i++) step();
    check("cnt_sat", int'(result), (1 << RW) - 1);
    step();
    check("cnt_hold", int'(result), (1 << RW) - 1);
    idle();

    // clear wins over a simultaneous push
    push = 1; s0 = 2'd0; step(); idle();
    check("pre_clr_empty", int'(empty), 0);
    clr = 1; push = 1; cnt = 1; step(); idle(); top = 1; #1;
    check("clr_push_empty", int'(empty), 1);
    check("clr_push_result", int'(result), 0);
    check("clr_push_stack_out", int'(stack_out), 0);
    check_model("final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
